// File: rtl/ring_ptr_ctrl_if.sv
// Handshake bundle between the operand producer/consumer and ring_ptr_ctrl.
// The master side drives push requests and pop acceptance.
// The slave side (the controller) returns ready/valid and the head word.
interface ring_ptr_ctrl_if #(
    parameter int DataWidth = 16
);
    logic                 PushValid;
    logic [DataWidth-1:0] PushData;
    logic                 PushReady;
    logic                 PopValid;
    logic [DataWidth-1:0] PopData;
    logic                 PopReady;

    modport master (
        output PushValid, PushData, PopReady,
        input  PushReady, PopValid, PopData
    );

    modport slave (
        input  PushValid, PushData, PopReady,
        output PushReady, PopValid, PopData
    );
endinterface

// File: rtl/ring_ptr_ctrl.sv
// Producer/consumer controller for the 4-entry circular MAC operand buffer.
// Owns the tail/head pointers, the lap bit and the entry storage, and exports
// TP/HP/Round so the ready-mask logic can decode per-entry ready bits.
// Full/Empty come from the lap bit: equal pointers mean full when TP is one
// lap ahead of HP, empty otherwise. BufferSize must equal 2**BufferWidth.
module ring_ptr_ctrl #(
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int DataWidth   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Flush,
    ring_ptr_ctrl_if.slave         bus,
    output logic [BufferWidth-1:0] TP,
    output logic [BufferWidth-1:0] HP,
    output logic                   Round,
    output logic [BufferWidth:0]   Count,
    output logic                   Full,
    output logic                   Empty
);

    localparam logic [BufferWidth-1:0] LastSlot = BufferWidth'(BufferSize - 1);

    logic [DataWidth-1:0] mem [BufferSize];
    logic                 ptr_eq;
    logic                 push_fire;
    logic                 pop_fire;
    logic                 push_wrap;
    logic                 pop_wrap;

    // Status flags and handshake qualifiers, decoded only from registered state.
    always_comb begin
        ptr_eq        = (TP == HP);
        Full          = Round && ptr_eq;
        Empty         = !Round && ptr_eq;
        bus.PushReady = !Full;
        bus.PopValid  = !Empty;
        bus.PopData   = mem[HP];
        push_fire     = bus.PushValid && !Full;
        pop_fire      = bus.PopReady && !Empty;
        push_wrap     = push_fire && (TP == LastSlot);
        pop_wrap      = pop_fire && (HP == LastSlot);
    end

    // Pointer, lap bit and occupancy update; Flush wins over any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TP    <= '0;
            HP    <= '0;
            Round <= 1'b0;
            Count <= '0;
        end else if (Flush) begin
            TP    <= '0;
            HP    <= '0;
            Round <= 1'b0;
            Count <= '0;
        end else begin
            if (push_fire)
                TP <= TP + 1'b1;
            if (pop_fire)
                HP <= HP + 1'b1;
            // Wraps on both sides in one cycle cancel out.
            if (push_wrap ^ pop_wrap)
                Round <= ~Round;
            if (push_fire && !pop_fire)
                Count <= Count + 1'b1;
            else if (pop_fire && !push_fire)
                Count <= Count - 1'b1;
        end
    end

    // Entry storage is write-only on push and never cleared; a flushed push is dropped.
    always_ff @(posedge clk) begin
        if (push_fire && !Flush)
            mem[TP] <= bus.PushData;
    end

endmodule
